// File: rtl/apb_master_if.sv
// APB bus bundle between the apb_master requester and an APB completer.
// Ports: PSEL/PENABLE/PWRITE/PADDR/PWDATA from the master; PRDATA/PREADY/PSLVERR from the slave.
interface apb_master_if;

    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    modport master (
        output PSEL,
        output PENABLE,
        output PWRITE,
        output PADDR,
        output PWDATA,
        input  PRDATA,
        input  PREADY,
        input  PSLVERR
    );

    modport slave (
        input  PSEL,
        input  PENABLE,
        input  PWRITE,
        input  PADDR,
        input  PWDATA,
        output PRDATA,
        output PREADY,
        output PSLVERR
    );

endinterface

// File: rtl/apb_master.sv
// APB master: turns cmd_valid/cmd_ready requests into SETUP/ACCESS transfers
// and returns a one-cycle rsp_valid pulse with read data and error status.
// Ports: PCLK, RESET (async active-low), cmd_* request channel, rsp_* response,
// apb (apb_master_if.master) carrying the APB bus signals.
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         PCLK,
    input  logic         RESET,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_write,
    input  logic [7:0]   cmd_addr,
    input  logic [7:0]   cmd_wdata,
    output logic         rsp_valid,
    output logic [7:0]   rsp_rdata,
    output logic         rsp_err,
    apb_master_if.master apb
);

    // State bits double as {PSEL, PENABLE}, so both bus strobes come
    // straight out of flops with no decode glitches.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b10,
        ACCESS = 2'b11
    } state_t;

    localparam logic       TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'd0;

    state_t     state_q, state_d;
    logic       pwrite_q, pwrite_d;
    logic [7:0] paddr_q, paddr_d;
    logic [7:0] pwdata_q, pwdata_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       rv_q, rv_d;
    logic [7:0] rd_q, rd_d;
    logic       re_q, re_d;

    logic       accept;
    logic       timeout_hit;

    // In ACCESS a new command may only ride on a completing transfer;
    // PREADY=1 already excludes a timeout in the same cycle.
    assign cmd_ready = RESET &&
                       ((state_q == IDLE) ||
                        ((state_q == ACCESS) && apb.PREADY));

    assign accept = cmd_valid && cmd_ready;

    assign timeout_hit = TO_EN && !apb.PREADY &&
                         (wcnt_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        wcnt_d   = wcnt_q;
        rv_d     = 1'b0;
        rd_d     = rd_q;
        re_d     = re_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    wcnt_d   = 8'd0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    rv_d = 1'b1;
                    rd_d = pwrite_q ? 8'd0 : apb.PRDATA;
                    re_d = apb.PSLVERR;
                    if (accept) begin
                        pwrite_d = cmd_write;
                        paddr_d  = cmd_addr;
                        pwdata_d = cmd_wdata;
                        wcnt_d   = 8'd0;
                        state_d  = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout_hit) begin
                    rv_d    = 1'b1;
                    rd_d    = 8'd0;
                    re_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= 8'd0;
            pwdata_q <= 8'd0;
            wcnt_q   <= 8'd0;
            rv_q     <= 1'b0;
            rd_q     <= 8'd0;
            re_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            wcnt_q   <= wcnt_d;
            rv_q     <= rv_d;
            rd_q     <= rd_d;
            re_q     <= re_d;
        end
    end

    assign apb.PSEL    = state_q[1];
    assign apb.PENABLE = state_q[0];
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;

    assign rsp_valid = rv_q;
    assign rsp_rdata = rd_q;
    assign rsp_err   = re_q;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter: TIMEOUT, default 16, max ACCESS wait cycles (PREADY=0) before abort; 0 disables timeout; range 0-255.
REQ-002 PCLK  input  1  clock; all state changes on posedge.
REQ-003 RESET  input  1  asynchronous, active-low reset; asserting it forces reset state immediately, independent of PCLK.
REQ-004 cmd_valid  input  1  command request from local requester.
REQ-005 cmd_ready  output  1  command accepted at posedge when cmd_valid=1 and cmd_ready=1.
REQ-006 cmd_write  input  1  1=write, 0=read.
REQ-007 cmd_addr  input  8  transfer address.
REQ-008 cmd_wdata  input  8  write data; ignored for reads.
REQ-009 rsp_valid  output  1  one-cycle pulse, transfer finished.
REQ-010 rsp_rdata  output  8  read data; 0 for writes and aborted transfers.
REQ-011 rsp_err  output  1  1 = PSLVERR returned or timeout abort.
REQ-012 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-013 PADDR, PWDATA  output  8 each  APB address and write data.
REQ-014 PRDATA  input  8  APB read data.
REQ-015 PREADY, PSLVERR  input  1 each  completer ready/error; slaves without wait states tie PREADY=1, PSLVERR=0.

Function
REQ-016 FSM states: IDLE (PSEL=0, PENABLE=0), SETUP (PSEL=1, PENABLE=0), ACCESS (PSEL=1, PENABLE=1); PSEL/PENABLE registered, decoded from state only.
REQ-017 cmd_ready combinational: 1 in IDLE, 1 in ACCESS when PREADY=1 and no timeout this cycle, else 0.
REQ-018 IDLE: accept -> capture cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA, next state SETUP; else stay IDLE.
REQ-019 SETUP lasts exactly one cycle, unconditionally -> ACCESS.
REQ-020 ACCESS, PREADY=0: stay ACCESS, increment 8-bit wait counter; counter cleared on entry to SETUP.
REQ-021 ACCESS, PREADY=1: transfer completes; capture PRDATA (read) or 0 (write) into rsp_rdata, PSLVERR into rsp_err; next state SETUP if a new command accepted same edge (back-to-back, new PADDR/PWRITE/PWDATA loaded), else IDLE.
REQ-022 Timeout: TIMEOUT>0, PREADY=0 and wait counter = TIMEOUT-1 in ACCESS -> abort at that edge: rsp_err=1, rsp_rdata=0, next state IDLE, no command accepted.
REQ-023 PREADY=1 in the same cycle as timeout condition: completion wins, no abort.
REQ-024 rsp_valid asserted in the cycle following completion or abort, for exactly one cycle; rsp_rdata/rsp_err hold until next response.
REQ-025 PADDR, PWRITE, PWDATA stable from SETUP through final ACCESS cycle; in IDLE retain last transfer values.
REQ-026 PSLVERR and PRDATA sampled only in ACCESS with PREADY=1; ignored otherwise.
REQ-027 Minimum transfer: 2 cycles (SETUP+ACCESS); back-to-back throughput one transfer per 2 cycles.

Reset
REQ-028 While RESET=0: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, cmd_ready=0.
REQ-029 Reset asserted mid-transfer (SETUP or ACCESS): transfer dropped, no rsp_valid generated, PSEL/PENABLE drop asynchronously.
REQ-030 First command accepted at first posedge after RESET deasserts with cmd_valid=1.

Verification
REQ-031 Write, PREADY=1: cmd write addr 0x3C data 0xA5 -> SETUP 1 cycle, ACCESS 1 cycle with PADDR=0x3C PWDATA=0xA5 PWRITE=1; rsp_valid next cycle, rsp_err=0, rsp_rdata=0.
REQ-032 Read with 2 wait states: read addr 0x3C, PREADY low 2 ACCESS cycles then high with PRDATA=0xA5 -> ACCESS lasts 3 cycles, rsp_rdata=0xA5, rsp_err=0.
REQ-033 Back-to-back: cmd_valid held with write 0x01 then read 0x02, PREADY=1 -> PSEL stays 1 for 4 cycles, PENABLE pattern 0,1,0,1, two rsp_valid pulses 2 cycles apart.
REQ-034 Error and timeout: PSLVERR=1 with PREADY=1 -> rsp_err=1; PREADY stuck 0 with TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSEL=0 next cycle.
REQ-035 Reset mid-ACCESS: RESET low during wait state -> PSEL/PENABLE 0 immediately, no rsp_valid; after release new write completes normally.
